serial_addsub: RTL

- Bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
- Processes one bit per clock, LSB first. Subtract is the primary mode: A - B is computed as A + ~B + 1.
- Sits beside the combinational ripple adder in the ALU datapath as the area-minimal sequential alternative.
- Uses a start/busy/done handshake toward the control unit.

---
 rtl/serial_addsub_if.sv | 27 ++
 rtl/serial_addsub.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master (control unit) drives the request; the slave returns status and flags.
interface serial_addsub_if #(
   parameter int unsigned N = 8
);
   logic         start;
   logic         sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         carry;
   logic         borrow;
   logic         overflow;
   logic         zero;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, carry, borrow, overflow, zero
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, carry, borrow, overflow, zero
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop, LSB first.
// Subtraction is A + ~B + 1; result and flags are held registers updated on completion.
module serial_addsub #(
   parameter int unsigned N = 8
) (
   input logic            clk,
   input logic            rst,
   serial_addsub_if.slave bus
);
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           c_q, c_d;
   logic           mode_q, mode_d;
   logic [N-1:0]   result_q, result_d;
   logic           carry_q, carry_d;
   logic           borrow_q, borrow_d;
   logic           overflow_q, overflow_d;
   logic           zero_q, zero_d;

   logic           sum_bit;
   logic           cout;
   logic [N-1:0]   res_full;

   assign sum_bit  = a_q[0] ^ b_q[0] ^ c_q;
   assign cout     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
   // Sum bits are shifted into the vacated top of the A register.
   assign res_full = {sum_bit, a_q[N-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         c_q        <= 1'b0;
         mode_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         c_q        <= c_d;
         mode_q     <= mode_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      c_d        = c_q;
      mode_d     = mode_q;
      result_d   = result_q;
      carry_d    = carry_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               c_d     = bus.sub;
               mode_d  = bus.sub;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            a_d   = res_full;
            b_d   = {1'b0, b_q[N-1:1]};
            c_d   = cout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               // c_q is the carry into the MSB at this point.
               result_d   = res_full;
               carry_d    = cout;
               overflow_d = c_q ^ cout;
               borrow_d   = mode_q & ~cout;
               zero_d     = (res_full == '0);
               state_d    = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy     = (state_q == StShift);
   assign bus.done     = (state_q == StDone);
   assign bus.result   = result_q;
   assign bus.carry    = carry_q;
   assign bus.borrow   = borrow_q;
   assign bus.overflow = overflow_q;
   assign bus.zero     = zero_q;
endmodule
